button_event_ctrl: RTL and testbench

//  Multi-button debounce controller and event scheduler. It shares one sample-tick prescaler across
//  N_BTN raw button inputs and gives each input its own synchroniser and stability counter.

---
 rtl/button_event_ctrl.sv | 140 ++++++++++++++
 tb/tb_button_event_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_ctrl.sv
// Debounces N_BTN raw buttons off one shared sample tick and schedules the resulting
// press/release events round-robin onto a single valid/ready output.
module button_event_ctrl #(
    parameter int unsigned N_BTN        = 4,
    parameter int unsigned TICK_DIV     = 1000,
    parameter int unsigned STABLE_TICKS = 4,
    localparam int unsigned ID_W        = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N_BTN-1:0] i_button,
    output logic [N_BTN-1:0] o_level,
    output logic            o_evt_valid,
    input  logic            i_evt_ready,
    output logic [ID_W-1:0] o_evt_id,
    output logic            o_evt_press,
    output logic            o_overflow,
    input  logic            i_clr_overflow
);

    localparam int unsigned TICK_W = $clog2(TICK_DIV);
    localparam int unsigned STAB_W = $clog2(STABLE_TICKS) + 1;

    logic [N_BTN-1:0]  r_sync1;
    logic [N_BTN-1:0]  r_sync2;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [STAB_W-1:0] r_stab [N_BTN];
    logic [N_BTN-1:0]  r_level;
    logic [N_BTN-1:0]  r_pend;
    logic [N_BTN-1:0]  r_pend_dir;
    logic [ID_W-1:0]   r_rr_ptr;
    logic              r_evt_valid;
    logic [ID_W-1:0]   r_evt_id;
    logic              r_evt_press;
    logic              r_overflow;

    logic              w_tick;
    logic [N_BTN-1:0]  w_accept;
    logic [ID_W-1:0]   w_grant;
    logic              w_found;
    logic              w_load;
    logic [N_BTN-1:0]  w_grant_oh;
    logic              w_ovf_set;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        wrap_idx = ID_W'((int'(base) + off) % int'(N_BTN));
    endfunction

    assign w_tick = (r_tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_tick_cnt <= '0;
        end else begin
            r_sync1    <= i_button;
            r_sync2    <= r_sync1;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
        end
    end

    always_comb begin
        w_accept = '0;
        for (int i = 0; i < int'(N_BTN); i++) begin
            w_accept[i] = w_tick && (r_sync2[i] != r_level[i]) &&
                          (r_stab[i] == STAB_W'(STABLE_TICKS - 1));
        end
    end

    // Any tick that sees the settled level again restarts the count (bounce rejection).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(N_BTN); i++) r_stab[i] <= '0;
            r_level <= '0;
        end else if (w_tick) begin
            for (int i = 0; i < int'(N_BTN); i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_stab[i] <= '0;
                end else if (w_accept[i]) begin
                    r_stab[i]  <= '0;
                    r_level[i] <= r_sync2[i];
                end else begin
                    r_stab[i] <= r_stab[i] + 1'b1;
                end
            end
        end
    end

    // Descending scan so the lowest offset from the pointer wins.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = int'(N_BTN) - 1; k >= 0; k--) begin
            if (r_pend[wrap_idx(r_rr_ptr, k)]) begin
                w_found = 1'b1;
                w_grant = wrap_idx(r_rr_ptr, k);
            end
        end
        w_load     = !r_evt_valid || i_evt_ready;
        w_grant_oh = '0;
        if (w_load && w_found) w_grant_oh[w_grant] = 1'b1;
        w_ovf_set  = |(w_accept & r_pend & ~w_grant_oh);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend      <= '0;
            r_pend_dir  <= '0;
            r_rr_ptr    <= '0;
            r_evt_valid <= 1'b0;
            r_evt_id    <= '0;
            r_evt_press <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_pend     <= (r_pend & ~w_grant_oh) | w_accept;
            r_pend_dir <= (r_pend_dir & ~w_accept) | (r_sync2 & w_accept);
            if (w_load) begin
                r_evt_valid <= w_found;
                if (w_found) begin
                    r_evt_id    <= w_grant;
                    r_evt_press <= r_pend_dir[w_grant];
                    r_rr_ptr    <= wrap_idx(w_grant, 1);
                end
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (i_clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_level     = r_level;
    assign o_evt_valid = r_evt_valid;
    assign o_evt_id    = r_evt_id;
    assign o_evt_press = r_evt_press;
    assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: per-cycle reference model plus directed scenarios with
// hand-computed event sequences and latencies.
module tb_button_event_ctrl;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int ST = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] button = '0;
    logic       ready = 1'b1;
    logic       clr = 1'b0;
    logic [3:0] level;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_press;
    logic       overflow;

    always #5 clk = ~clk;

    button_event_ctrl #(
        .N_BTN        (N),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_button       (button),
        .o_level        (level),
        .o_evt_valid    (evt_valid),
        .i_evt_ready    (ready),
        .o_evt_id       (evt_id),
        .o_evt_press    (evt_press),
        .o_overflow     (overflow),
        .i_clr_overflow (clr)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts consecutive disagreeing ticks per channel, keeps a pending
    // slot per channel and an output register fed by a rotating scan.
    bit [3:0] m_s1, m_s2, m_level, m_pend, m_dir;
    int       m_cnt, m_ptr, m_id;
    int       m_run [4];
    bit       m_valid, m_press, m_ovf;

    always @(posedge clk) begin : model
        bit [3:0] old_s2;
        bit [3:0] acc;
        bit       tick;
        bit       set;
        int       g;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; m_pend = '0; m_dir = '0;
            m_cnt = 0; m_ptr = 0; m_id = 0; m_valid = 0; m_press = 0; m_ovf = 0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
        end else begin
            old_s2 = m_s2;
            m_s2   = m_s1;
            m_s1   = button;
            tick   = (m_cnt == TD - 1);
            m_cnt  = (m_cnt + 1) % TD;
            acc    = '0;
            if (tick) begin
                for (int i = 0; i < N; i++) begin
                    if (old_s2[i] != m_level[i]) begin
                        m_run[i]++;
                        if (m_run[i] == ST) begin
                            acc[i]     = 1'b1;
                            m_level[i] = old_s2[i];
                            m_run[i]   = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            if (!m_valid || ready) begin
                g = -1;
                for (int k = N - 1; k >= 0; k--) if (m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                if (g >= 0) begin
                    m_valid = 1; m_id = g; m_press = m_dir[g]; m_pend[g] = 0; m_ptr = (g + 1) % N;
                end else begin
                    m_valid = 0;
                end
            end
            set = 0;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    if (m_pend[i]) set = 1;
                    m_pend[i] = 1;
                    m_dir[i]  = old_s2[i];
                end
            end
            if (set) m_ovf = 1;
            else if (clr) m_ovf = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_level", 32'(level), 32'(m_level));
            chk("model_evt_valid", 32'(evt_valid), 32'(m_valid));
            chk("model_evt_id", 32'(evt_id), 32'(m_id));
            chk("model_evt_press", 32'(evt_press), 32'(m_press));
            chk("model_overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    // Handshake log.
    int ev_id[$];
    int ev_press[$];
    int ev_t[$];
    int cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (!rst && evt_valid && ready) begin
            ev_id.push_back(int'(evt_id));
            ev_press.push_back(int'(evt_press));
            ev_t.push_back(cyc);
        end
    end

    task automatic clear_log();
        ev_id.delete();
        ev_press.delete();
        ev_t.delete();
    endtask

    task automatic expect_evt(input string name, input int idx, input int id, input int press);
        if (ev_id.size() > idx) begin
            chk({name, "_id"}, 32'(ev_id[idx]), 32'(id));
            chk({name, "_press"}, 32'(ev_press[idx]), 32'(press));
        end else begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: event %0d missing, got %0d events", name, idx, ev_id.size());
        end
    endtask

    task automatic do_reset(input logic [3:0] btn);
        @(negedge clk);
        rst = 1'b1; button = '0; clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; button = btn;
        clear_log();
    endtask

    initial begin
        int n;
        // 1: reset
        repeat (3) begin
            @(negedge clk);
            chk_en = 1'b1;
            chk("t1_rst_level", 32'(level), 0);
            chk("t1_rst_valid", 32'(evt_valid), 0);
            chk("t1_rst_ovf", 32'(overflow), 0);
        end
        rst = 1'b0;
        clear_log();
        repeat (10) @(negedge clk);
        chk("t1_idle_level", 32'(level), 0);
        chk("t1_idle_valid", 32'(evt_valid), 0);
        chk("t1_idle_events", 32'(ev_id.size()), 0);

        // 2: single press then release
        do_reset(4'b0010);
        ready = 1'b1;
        n = 0;
        while (n < 20 && !level[1]) begin
            @(negedge clk);
            n++;
        end
        chk("t2_press_latency", 32'(n), 12);
        repeat (10) @(negedge clk);
        chk("t2_press_events", 32'(ev_id.size()), 1);
        expect_evt("t2_press", 0, 1, 1);
        clear_log();
        button = 4'b0000;
        repeat (25) @(negedge clk);
        chk("t2_rel_level", 32'(level), 0);
        chk("t2_rel_events", 32'(ev_id.size()), 1);
        expect_evt("t2_rel", 0, 1, 0);

        // 3: bouncing input never settles long enough
        do_reset(4'b0000);
        repeat (8) begin
            button[2] = 1'b1;
            repeat (2) @(negedge clk);
            button[2] = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        chk("t3_level2", 32'(level[2]), 0);
        chk("t3_events", 32'(ev_id.size()), 0);

        // 4: simultaneous presses, then held output under back-pressure
        do_reset(4'b0101);
        n = 0;
        while (n < 25 && ev_id.size() < 2) begin
            @(negedge clk);
            n++;
        end
        chk("t4_events", 32'(ev_id.size()), 2);
        expect_evt("t4_first", 0, 0, 1);
        expect_evt("t4_second", 1, 2, 1);
        if (ev_t.size() >= 2) chk("t4_back_to_back", 32'(ev_t[1] - ev_t[0]), 1);
        repeat (3) @(negedge clk);
        clear_log();
        ready = 1'b0;
        button = 4'b0000;
        n = 0;
        while (n < 25 && !evt_valid) begin
            @(negedge clk);
            n++;
        end
        repeat (5) begin
            chk("t4_hold_valid", 32'(evt_valid), 1);
            chk("t4_hold_id", 32'(evt_id), 0);
            chk("t4_hold_press", 32'(evt_press), 0);
            @(negedge clk);
        end
        ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("t4_rel_events", 32'(ev_id.size()), 2);
        expect_evt("t4_rel_first", 0, 0, 0);
        expect_evt("t4_rel_second", 1, 2, 0);

        // 5: overwrite of an unsent event raises overflow
        do_reset(4'b0001);
        ready = 1'b0;
        n = 0;
        while (n < 25 && !evt_valid) begin
            @(negedge clk);
            n++;
        end
        button = 4'b1001;
        n = 0;
        while (n < 25 && !level[3]) begin
            @(negedge clk);
            n++;
        end
        chk("t5_level3_up", 32'(level[3]), 1);
        chk("t5_ovf_after_press", 32'(overflow), 0);
        button = 4'b0001;
        n = 0;
        while (n < 25 && level[3]) begin
            @(negedge clk);
            n++;
        end
        chk("t5_level3_down", 32'(level[3]), 0);
        chk("t5_ovf_after_release", 32'(overflow), 1);
        ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("t5_events", 32'(ev_id.size()), 2);
        expect_evt("t5_first", 0, 0, 1);
        expect_evt("t5_second", 1, 3, 0);
        chk("t5_ovf_sticky", 32'(overflow), 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("t5_ovf_cleared", 32'(overflow), 0);

        // 6: reset mid-count discards accumulated stability
        do_reset(4'b0010);
        ready = 1'b1;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        repeat (11) @(negedge clk);
        chk("t6_level_before", 32'(level[1]), 0);
        chk("t6_events_before", 32'(ev_id.size()), 0);
        @(negedge clk);
        chk("t6_level_after", 32'(level[1]), 1);
        repeat (3) @(negedge clk);
        chk("t6_events", 32'(ev_id.size()), 1);
        expect_evt("t6_evt", 0, 1, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
